// File: rtl/motor_input_cond_if.sv
`default_nettype none
// ============================================================================
// Module      : motor_input_cond_if
// Description : Signal bundle between the raw motor-panel contacts and the
//               input conditioning stage.
//               master : drives the raw contacts, observes conditioned levels
//               slave  : the conditioning stage itself
//   btn_raw, up_limit_raw, dn_limit_raw : raw asynchronous bouncy contacts
//   activate                            : one-cycle pulse per button press
//   up_limit, dn_limit                  : debounced limit-switch levels
//   fault                               : limit-interlock fault level
// Revision    : 1.0 - initial release
// ============================================================================
interface motor_input_cond_if;
    logic btn_raw;
    logic up_limit_raw;
    logic dn_limit_raw;
    logic activate;
    logic up_limit;
    logic dn_limit;
    logic fault;

    modport master (
        output btn_raw, up_limit_raw, dn_limit_raw,
        input  activate, up_limit, dn_limit, fault
    );

    modport slave (
        input  btn_raw, up_limit_raw, dn_limit_raw,
        output activate, up_limit, dn_limit, fault
    );
endinterface
`default_nettype wire

// File: rtl/motor_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : motor_input_cond
// Description : Synchronises and debounces the push-button and the two limit
//               switches feeding the motor control FSM. Produces clean limit
//               levels and a single-cycle activate pulse per button press.
//   clk    : single clock, rising edge
//   rst_n  : asynchronous assert, active-low reset
//   bus    : motor_input_cond_if.slave (raw contacts in, conditioned out)
// Parameters  : DEBOUNCE_CYCLES (1 .. 2**CNT_W-1), CNT_W
// Build macro : MOTOR_INPUT_COND_INTERLOCK_EN - when defined, both limits
//               active together raise fault and suppress activate.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_input_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    motor_input_cond_if.slave   bus
);

    localparam int              c_num_ch   = 3;
    localparam int              c_ch_btn   = 0;
    localparam int              c_ch_up    = 1;
    localparam int              c_ch_dn    = 2;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [c_num_ch-1:0] w_raw;
    logic [c_num_ch-1:0] w_db;
    logic [c_num_ch-1:0] w_db_next;
    logic                w_press;
    logic                w_fault_next;
    logic                r_activate;

    assign w_raw = {bus.dn_limit_raw, bus.up_limit_raw, bus.btn_raw};

    // Three identical channels: 2-flop synchroniser feeding a run-length
    // debouncer. The debounced level only flips after DEBOUNCE_CYCLES
    // consecutive synchronised samples that disagree with it.
    for (genvar g = 0; g < c_num_ch; g++) begin : g_ch
        logic             r_s1;
        logic             r_s2;
        logic             r_db;
        logic [CNT_W-1:0] r_cnt;
        logic             w_upd;

        assign w_upd        = (r_s2 != r_db) && (r_cnt == c_cnt_last);
        assign w_db_next[g] = w_upd ? r_s2 : r_db;
        assign w_db[g]      = r_db;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_db  <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
                r_db <= w_db_next[g];
                // Any agreeing sample, or an update, restarts the run.
                if (r_s2 == r_db || w_upd) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    end

    // Press = the button's debounced level is about to rise this edge.
    assign w_press = w_db_next[c_ch_btn] & ~w_db[c_ch_btn];

`ifdef MOTOR_INPUT_COND_INTERLOCK_EN
    logic r_fault;

    // Computed from next-state levels so fault lines up with the limit outputs.
    assign w_fault_next = w_db_next[c_ch_up] & w_db_next[c_ch_dn];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_next;
        end
    end

    assign bus.fault = r_fault;
`else
    assign w_fault_next = 1'b0;
    assign bus.fault    = 1'b0;
`endif

    // A press arriving while the interlock is (newly) tripped is swallowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_activate <= 1'b0;
        end else begin
            r_activate <= w_press & ~w_fault_next;
        end
    end

    assign bus.activate = r_activate;
    assign bus.up_limit = w_db[c_ch_up];
    assign bus.dn_limit = w_db[c_ch_dn];

endmodule
`default_nettype wire

// File: tb/tb_motor_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_input_cond
// Description : Self-checking bench for motor_input_cond. A sliding-window
//               model of each channel predicts the outputs after every edge;
//               predictions are queued and compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_input_cond;

    localparam int D = 16;

    typedef struct packed {
        logic act;
        logic up;
        logic dn;
        logic fault;
    } exp_t;

    logic clk;
    logic rst_n;
    motor_input_cond_if bus ();

    motor_input_cond #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];

    // Model state: debounced levels plus history of raw samples per channel.
    logic [2:0] m_db;
    logic       hist[3][$];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t got act/up/dn/fault=%b expected=%b", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_db = '0;
        for (int ch = 0; ch < 3; ch++) begin
            hist[ch].delete();
            // Synchroniser flops and the run count start at zero.
            for (int k = 0; k < D + 1; k++) hist[ch].push_back(1'b0);
        end
    endtask

    // A channel flips when the D samples that have reached the end of the
    // synchroniser (sampled 2 .. D+1 edges ago) all disagree with its level.
    task automatic model_edge();
        logic [2:0] raw;
        logic [2:0] nxt;
        logic       flt;
        exp_t       e;
        raw = {bus.dn_limit_raw, bus.up_limit_raw, bus.btn_raw};
        if (!rst_n) begin
            model_reset();
            q.push_back('0);
            return;
        end
        nxt = m_db;
        for (int ch = 0; ch < 3; ch++) begin
            int sz;
            bit all_diff;
            sz = hist[ch].size();
            all_diff = 1'b1;
            for (int k = sz - D - 1; k <= sz - 2; k++) begin
                if (hist[ch][k] == m_db[ch]) all_diff = 1'b0;
            end
            if (all_diff) nxt[ch] = ~m_db[ch];
            hist[ch].push_back(raw[ch]);
            if (hist[ch].size() > D + 2) void'(hist[ch].pop_front());
        end
`ifdef MOTOR_INPUT_COND_INTERLOCK_EN
        flt = nxt[1] & nxt[2];
`else
        flt = 1'b0;
`endif
        e.act   = nxt[0] & ~m_db[0] & ~flt;
        e.up    = nxt[1];
        e.dn    = nxt[2];
        e.fault = flt;
        m_db = nxt;
        q.push_back(e);
    endtask

    // raw = {dn, up, btn}; applied just after an edge, held for n edges.
    task automatic step(input logic [2:0] raw, input int n);
        #1;
        bus.btn_raw      = raw[0];
        bus.up_limit_raw = raw[1];
        bus.dn_limit_raw = raw[2];
        repeat (n) begin
            @(posedge clk);
            model_edge();
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async", {bus.activate, bus.up_limit, bus.dn_limit, bus.fault}, 4'b0000);
        q.delete();
        model_reset();
        repeat (3) begin
            @(posedge clk);
            model_edge();
        end
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every falling edge, compare against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("outputs", {bus.activate, bus.up_limit, bus.dn_limit, bus.fault}, e);
        end
    end

    initial begin
        logic [2:0] val;
        int         rem[3];

        rst_n            = 1'b0;
        bus.btn_raw      = 1'b1;
        bus.up_limit_raw = 1'b1;
        bus.dn_limit_raw = 1'b1;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        #1 rst_n = 1'b1;

        // All inputs high: reset mid-count, then let everything debounce.
        step(3'b111, 8);
        do_reset();
        step(3'b111, 40);
        // Reset again while levels are established.
        do_reset();
        step(3'b111, 30);

        // Clean press held 100 cycles, then release.
        step(3'b000, 40);
        step(3'b001, 100);
        step(3'b000, 40);

        // Bounce on the upper limit, then a genuine hold.
        for (int i = 0; i < 5; i++) begin
            step(3'b010, 15);
            step(3'b000, 3);
        end
        step(3'b010, 30);
        step(3'b000, 30);

        // Button and lower limit rise together.
        step(3'b101, 30);
        step(3'b000, 30);

        // Both limits high, press, release, drop lower limit, press again.
        step(3'b110, 30);
        step(3'b111, 30);
        step(3'b110, 30);
        step(3'b010, 30);
        step(3'b011, 30);
        step(3'b000, 40);

        // Randomised bouncy contacts: each channel holds for 1 .. 2D cycles.
        val = '0;
        for (int ch = 0; ch < 3; ch++) rem[ch] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (rem[ch] == 0) begin
                    val[ch] = ~val[ch];
                    rem[ch] = $urandom_range(1, 2 * D);
                end
                rem[ch]--;
            end
            step(val, 1);
            if (c == 1500) do_reset();
        end

        step(3'b000, 40);
        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_input_cond.md
# motor_input_cond

Input conditioning stage that sits directly upstream of the motor control FSM. It synchronises and debounces the raw push-button and the two raw limit-switch contacts. It delivers clean `up_limit` / `dn_limit` levels and a single-cycle `activate` pulse per button press, which the FSM consumes unchanged.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised input must differ from its debounced level before the level flips. Legal range is 1 .. 2^`CNT_W`-1.
- `CNT_W`, default 8: width of each per-channel debounce counter.

Ports:
- `clk`  input  1  single clock, all logic on rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `btn_raw`  input  1  raw push-button contact, asynchronous, bouncy. 1 = pressed.
- `up_limit_raw`  input  1  raw upper limit switch, asynchronous, bouncy.
- `dn_limit_raw`  input  1  raw lower limit switch, asynchronous, bouncy.
- `activate`  output  1  registered one-cycle pulse on each debounced button press.
- `up_limit`  output  1  registered debounced upper-limit level.
- `dn_limit`  output  1  registered debounced lower-limit level.
- `fault`  output  1  registered limit-interlock fault level. Constant 0 when the interlock is compiled out.

## Operation
- There are three identical channels: btn, up, dn. Each channel has:
  - a 2-flop synchroniser, `s1` then `s2`;
  - a `CNT_W`-bit counter `cnt`;
  - a debounced level `db`.
- Each cycle, per channel:
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s2` and `cnt <= 0` (an update event).
  - Else: `cnt <= cnt+1`.
- Any single cycle where `s2 == db` restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never reaches `db`.
- `up_limit` = `db` of the up channel; `dn_limit` = `db` of the dn channel. No inversion.
- `activate <= 1` exactly on the edge where the btn channel updates `db` from 0 to 1. Otherwise `activate <= 0`.
  - A release (1→0) produces no pulse.
  - Holding the button produces only one pulse.
- The counter never wraps. It is bounded by `DEBOUNCE_CYCLES-1` ≤ 2^`CNT_W`-1.
- The three channels are fully independent. Simultaneous update events on any combination of channels are all applied in the same cycle.
- Reset, including assertion mid-count or mid-pulse: all `s1`, `s2`, `cnt`, `db`, `activate`, and `fault` are forced to 0 immediately.
  - A limit switch held high through reset reappears on its output `DEBOUNCE_CYCLES+1` edges after the first sampling edge following `rst_n` release.
  - A button held through reset generates one `activate` when its debounced level rises.

## Timing
- Edge 0 is the first rising edge that samples a new stable raw level into `s1`. `s2` shows it after edge 1.
- `db` (and therefore `up_limit` / `dn_limit`) changes at edge `DEBOUNCE_CYCLES+1`. With the default of 16, that is edge 17.
- `activate` is high for exactly the one cycle following edge `DEBOUNCE_CYCLES+1` of a press.
- Minimum spacing between two `activate` pulses is 2·`DEBOUNCE_CYCLES` cycles: the release must debounce, then the next press.
- All outputs come straight from flops. There is no combinational path from any input to any output.

## Configuration
- `MOTOR_INPUT_COND_INTERLOCK_EN` defined:
  - `fault <= up_limit_next & dn_limit_next`. This is registered and aligned with the debounced outputs.
  - While the new `fault` value is 1, `activate` is forced to 0. A btn update event in such a cycle is consumed without a pulse.
  - `fault` clears on the edge where either debounced limit falls.
- `MOTOR_INPUT_COND_INTERLOCK_EN` not defined:
  - `fault` is tied to 0.
  - `activate` depends only on the btn channel.
  - No interlock logic is present.

## Test plan
- Reset behaviour: with all raw inputs high, assert `rst_n`=0 mid-count → all outputs are 0 immediately. After release, `up_limit` and `dn_limit` rise at edge 17 and `activate` pulses once (with the interlock defined: no pulse and `fault`=1 at edge 17).
- Clean press, `DEBOUNCE_CYCLES`=16: raise `btn_raw` and hold 100 cycles → exactly one `activate` pulse, one cycle wide, after edge 17. Release → no pulse.
- Bounce rejection: toggle `up_limit_raw` high for 15 cycles then low, repeated 5 times → `up_limit` stays 0. Then hold high 16+ cycles → `up_limit` rises at edge 17 of the final hold.
- Simultaneous events: raise `btn_raw` and `dn_limit_raw` on the same edge → `activate` pulse and `dn_limit` rise on the same edge.
- Interlock (macro defined): drive both limits high, then press the button → `fault`=1 and no `activate`. Drop `dn_limit_raw` → `fault` clears 17 edges later. A subsequent press pulses `activate`. With the macro undefined, the same stimulus gives `fault`=0 and a pulse.
